// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU select codes, EX->MEM payload record and the
//                occupancy encoding of the EX->MEM skid buffer.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam logic [1:0] ALU_SEL_AND = 2'b00;
    localparam logic [1:0] ALU_SEL_OR  = 2'b01;
    localparam logic [1:0] ALU_SEL_ADD = 2'b10;
    localparam logic [1:0] ALU_SEL_SLT = 2'b11;

    // Payload field widths; the stage's WIDTH/RD_W must match these.
    localparam int c_DATA_W = 32;
    localparam int c_RD_W   = 5;

    typedef struct packed {
        logic [c_DATA_W-1:0] result;
        logic                zero;
        logic                ovf;
        logic [c_RD_W-1:0]   rd;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic [c_DATA_W-1:0] store_data;
    } ex_mem_payload_t;

    // Encoding mirrors the {skid_valid, main_valid} bit pair.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b11
    } skid_state_e;

endpackage
`default_nettype wire

// File: rtl/ex_mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_stage_if
//  Description : EX-side and MEM-side handshake/payload bundle for the
//                EX->MEM stage. master = EX producer + MEM consumer,
//                slave = the pipeline stage itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface ex_mem_stage_if #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
);
    // EX side
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_sel;
    logic             alu_inv;
    logic [WIDTH-1:0] alu_result;
    logic             a_msb;
    logic             b_msb;
    logic [RD_W-1:0]  rd;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic [WIDTH-1:0] store_data;
    // MEM side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_ovf;
    logic [RD_W-1:0]  out_rd;
    logic             out_reg_write;
    logic             out_mem_read;
    logic             out_mem_write;
    logic [WIDTH-1:0] out_store_data;

    modport master (
        output in_valid, alu_sel, alu_inv, alu_result, a_msb, b_msb, rd,
               reg_write, mem_read, mem_write, store_data, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_ovf, out_rd,
               out_reg_write, out_mem_read, out_mem_write, out_store_data
    );

    modport slave (
        input  in_valid, alu_sel, alu_inv, alu_result, a_msb, b_msb, rd,
               reg_write, mem_read, mem_write, store_data, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_ovf, out_rd,
               out_reg_write, out_mem_read, out_mem_write, out_store_data
    );
endinterface
`default_nettype wire

// File: rtl/ex_mem_stage_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : skid_buffer
//  Description : Two-entry valid/ready skid buffer. The main register drives
//                the outputs; the skid register catches the one item that
//                arrives while MEM stalls. Ready is a pure register decode,
//                so downstream ready never reaches upstream combinationally.
//  Revision    : 1.0  initial release
// ============================================================================
module skid_buffer
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         flush,
    input  wire logic         i_valid,
    output logic              o_ready,
    input  wire logic [W-1:0] i_data,
    output logic              o_valid,
    input  wire logic         i_ready,
    output logic [W-1:0]      o_data
);

    skid_state_e r_state;
    skid_state_e w_state_nxt;
    logic [W-1:0] r_main;
    logic [W-1:0] r_skid;
    logic         w_in_fire;
    logic         w_out_fire;
    logic         w_load_main;
    logic         w_main_from_skid;
    logic         w_load_skid;

    assign o_valid = (r_state != SKID_EMPTY);
    assign o_ready = (r_state != SKID_FULL);
    assign o_data  = r_main;

    // Flush suppresses both transfers so the killed cycle moves nothing.
    assign w_in_fire  = i_valid & o_ready & ~flush;
    assign w_out_fire = o_valid & i_ready & ~flush;

    // Next occupancy and which register gets loaded from where.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            SKID_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = SKID_ONE;
                    w_load_main = 1'b1;
                end
            end
            SKID_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main = 1'b1;
                end else if (w_in_fire) begin
                    w_state_nxt = SKID_FULL;
                    w_load_skid = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (w_out_fire) begin
                    w_state_nxt      = SKID_ONE;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = SKID_EMPTY;
        endcase
        if (flush) begin
            w_state_nxt = SKID_EMPTY;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SKID_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Payload registers change only on a load, keeping outputs stable under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) begin
                r_main <= i_data;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= i_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_mem_stage
//  Description : EX->MEM pipeline register. Derives zero/overflow flags from
//                the ALU result, packs them with control into one payload and
//                passes it through a two-entry skid buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module ex_mem_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = c_DATA_W,
    parameter int RD_W  = c_RD_W
) (
    input  wire logic      clk,
    input  wire logic      rst,
    input  wire logic      flush,
    ex_mem_stage_if.slave  bus
);

    localparam int c_PAYLOAD_W = $bits(ex_mem_payload_t);

    logic            w_zero;
    logic            w_b_eff;
    logic            w_ovf;
    ex_mem_payload_t w_pkt_in;
    ex_mem_payload_t w_pkt_out;
    logic [c_PAYLOAD_W-1:0] w_data_out;

    // Overflow only means something for ADD/SUB: operands of equal effective
    // sign producing a result of the opposite sign.
    assign w_zero  = ~|bus.alu_result;
    assign w_b_eff = bus.b_msb ^ bus.alu_inv;
    assign w_ovf   = (bus.alu_sel == ALU_SEL_ADD) &
                     (bus.a_msb == w_b_eff) &
                     (bus.alu_result[WIDTH-1] != bus.a_msb);

    // Pack the incoming instruction into the buffered record.
    always_comb begin
        w_pkt_in            = '0;
        w_pkt_in.result     = bus.alu_result;
        w_pkt_in.zero       = w_zero;
        w_pkt_in.ovf        = w_ovf;
        w_pkt_in.rd         = bus.rd;
        w_pkt_in.reg_write  = bus.reg_write;
        w_pkt_in.mem_read   = bus.mem_read;
        w_pkt_in.mem_write  = bus.mem_write;
        w_pkt_in.store_data = bus.store_data;
    end

    skid_buffer #(
        .W (c_PAYLOAD_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .i_valid (bus.in_valid),
        .o_ready (bus.in_ready),
        .i_data  (w_pkt_in),
        .o_valid (bus.out_valid),
        .i_ready (bus.out_ready),
        .o_data  (w_data_out)
    );

    assign w_pkt_out = ex_mem_payload_t'(w_data_out);

    assign bus.out_result     = w_pkt_out.result;
    assign bus.out_zero       = w_pkt_out.zero;
    assign bus.out_ovf        = w_pkt_out.ovf;
    assign bus.out_rd         = w_pkt_out.rd;
    assign bus.out_reg_write  = w_pkt_out.reg_write;
    assign bus.out_mem_read   = w_pkt_out.mem_read;
    assign bus.out_mem_write  = w_pkt_out.mem_write;
    assign bus.out_store_data = w_pkt_out.store_data;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_mem_stage
//  Description : Self-checking bench for ex_mem_stage: directed corner cases
//                plus random traffic against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ex_mem_stage;

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        ovf;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [31:0] sd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Staged stimulus, applied by tick()
    logic        s_valid, s_ready, s_flush, s_rst, s_inv, s_rw, s_mr, s_mw;
    logic [1:0]  s_sel;
    logic [31:0] s_a, s_b, s_sd;
    logic [4:0]  s_rd;

    exp_t mq[$];

    ex_mem_stage_if #(.WIDTH(32), .RD_W(5)) bus ();

    ex_mem_stage #(.WIDTH(32), .RD_W(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural ALU with plain arithmetic.
    function automatic logic [31:0] alu_ref(input logic [1:0] sel, input logic inv,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [31:0] bb;
        bb = inv ? ~b : b;
        case (sel)
            2'b00:   return a & bb;
            2'b01:   return a | bb;
            2'b10:   return inv ? (a - b) : (a + b);
            default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    // Signed overflow from wide-integer arithmetic, only for ADD/SUB.
    function automatic logic ovf_ref(input logic [1:0] sel, input logic inv,
                                     input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, s;
        if (sel != 2'b10) return 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = inv ? (sa - sb) : (sa + sb);
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    // One clock: drive staged inputs at negedge, update model, check after posedge.
    task automatic tick();
        exp_t e;
        int   n;
        @(negedge clk);
        rst            = s_rst;
        flush          = s_flush;
        bus.in_valid   = s_valid;
        bus.out_ready  = s_ready;
        bus.alu_sel    = s_sel;
        bus.alu_inv    = s_inv;
        bus.alu_result = alu_ref(s_sel, s_inv, s_a, s_b);
        bus.a_msb      = s_a[31];
        bus.b_msb      = s_b[31];
        bus.rd         = s_rd;
        bus.reg_write  = s_rw;
        bus.mem_read   = s_mr;
        bus.mem_write  = s_mw;
        bus.store_data = s_sd;
        e.result = alu_ref(s_sel, s_inv, s_a, s_b);
        e.zero   = (e.result == 32'd0);
        e.ovf    = ovf_ref(s_sel, s_inv, s_a, s_b);
        e.rd     = s_rd;
        e.rw     = s_rw;
        e.mr     = s_mr;
        e.mw     = s_mw;
        e.sd     = s_sd;
        n = mq.size();
        if (s_rst || s_flush) begin
            mq.delete();
        end else begin
            if (n > 0 && s_ready) mq.delete(0);
            if (s_valid && n < 2) mq.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
        chk("in_ready", 64'(bus.in_ready), 64'(mq.size() < 2));
        if (mq.size() > 0) begin
            chk("out_result", 64'(bus.out_result), 64'(mq[0].result));
            chk("out_zero", 64'(bus.out_zero), 64'(mq[0].zero));
            chk("out_ovf", 64'(bus.out_ovf), 64'(mq[0].ovf));
            chk("out_rd", 64'(bus.out_rd), 64'(mq[0].rd));
            chk("out_ctl", 64'({bus.out_reg_write, bus.out_mem_read, bus.out_mem_write}),
                64'({mq[0].rw, mq[0].mr, mq[0].mw}));
            chk("out_store_data", 64'(bus.out_store_data), 64'(mq[0].sd));
        end
    endtask

    task automatic rand_pkt();
        s_sel = 2'($urandom_range(0, 3));
        s_inv = 1'($urandom_range(0, 1));
        s_a   = $urandom;
        s_b   = ($urandom_range(0, 7) == 0) ? s_a : $urandom;
        s_rd  = 5'($urandom);
        s_rw  = 1'($urandom);
        s_mr  = 1'($urandom);
        s_mw  = 1'($urandom);
        s_sd  = $urandom;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
        chk({tag, "_payload"}, 64'({bus.out_result, bus.out_zero, bus.out_ovf, bus.out_rd,
            bus.out_reg_write, bus.out_mem_read, bus.out_mem_write} | {32'd0, bus.out_store_data}), 64'd0);
        chk({tag, "_store"}, 64'(bus.out_store_data), 64'd0);
    endtask

    initial begin
        s_valid = 0; s_ready = 1; s_flush = 0; s_rst = 1;
        rand_pkt();
        tick();
        tick();
        chk_all_zero("reset");
        s_rst = 0;

        // ADD overflow: 0x7FFFFFFF + 1
        s_valid = 1; s_ready = 1;
        s_sel = 2'b10; s_inv = 0; s_a = 32'h7FFF_FFFF; s_b = 32'd1;
        tick();
        chk("add_ovf", 64'(bus.out_ovf), 64'd1);
        chk("add_zero", 64'(bus.out_zero), 64'd0);
        chk("add_result", 64'(bus.out_result), 64'h8000_0000);

        // SUB equal operands
        s_inv = 1; s_a = 32'h1234_5678; s_b = 32'h1234_5678;
        tick();
        chk("sub_zero", 64'(bus.out_zero), 64'd1);
        chk("sub_ovf", 64'(bus.out_ovf), 64'd0);

        // SLT true, with operand signs that would flag overflow under ADD rules
        s_sel = 2'b11; s_inv = 1; s_a = 32'h8000_0000; s_b = 32'h0000_0001;
        tick();
        chk("slt_result", 64'(bus.out_result), 64'd1);
        chk("slt_ovf", 64'(bus.out_ovf), 64'd0);

        // Stream 8 back-to-back
        s_valid = 0;
        tick();
        s_valid = 1;
        for (int i = 0; i < 8; i++) begin
            rand_pkt();
            s_rd = 5'(i + 3);
            tick();
            chk("stream_rd", 64'(bus.out_rd), 64'(i + 3));
            chk("stream_ready", 64'(bus.in_ready), 64'd1);
        end

        // Back-pressure: A, B accepted, C refused
        s_valid = 0;
        tick();
        s_ready = 0; s_valid = 1;
        rand_pkt(); s_rd = 5'd10; tick();
        rand_pkt(); s_rd = 5'd11; tick();
        rand_pkt(); s_rd = 5'd12; tick();
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_head", 64'(bus.out_rd), 64'd10);
        tick();
        chk("bp_stable", 64'(bus.out_rd), 64'd10);
        s_ready = 1;
        tick();
        chk("bp_drain_b", 64'(bus.out_rd), 64'd11);
        tick();
        chk("bp_drain_c", 64'(bus.out_rd), 64'd12);
        s_valid = 0;
        tick();
        chk("bp_empty", 64'(bus.out_valid), 64'd0);

        // FULL then flush with an offer in the same cycle
        s_ready = 0; s_valid = 1;
        rand_pkt(); s_rd = 5'd20; tick();
        rand_pkt(); s_rd = 5'd21; tick();
        s_flush = 1; rand_pkt(); s_rd = 5'd22; tick();
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_ready", 64'(bus.in_ready), 64'd1);
        s_flush = 0; s_valid = 0; s_ready = 1;
        tick();
        tick();
        chk("flush_dropped", 64'(bus.out_valid), 64'd0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            rand_pkt();
            s_valid = 1'($urandom_range(0, 3) != 0);
            s_ready = 1'($urandom_range(0, 2) != 0);
            s_flush = ($urandom_range(0, 31) == 0);
            tick();
        end
        s_flush = 0;

        // Reset mid-traffic for two cycles
        s_valid = 1; s_ready = 0;
        rand_pkt(); tick();
        rand_pkt(); tick();
        s_rst = 1;
        tick();
        tick();
        s_rst = 0; s_valid = 0;
        chk_all_zero("mid_reset");
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
